// File: rtl/serial_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_pkg
// Purpose  : Shared definitions for the serial transmit scheduler: scheduler
//            state encoding, default converter widths and the grant-index
//            width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package serial_tx_pkg;

    // Scheduler states, 2-bit encoding
    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_ISSUE     = 2'd1;
    localparam logic [1:0] c_ST_WAIT_SENT = 2'd2;
    localparam logic [1:0] c_ST_GAP       = 2'd3;

    // Default converter interface widths
    localparam int c_DEF_PARALLEL_PORT_WIDTH = 15;
    localparam int c_DEF_BIT_LENGTH          = 4;

    // Width of an index that can name any of n requesters (at least 1 bit)
    function automatic int grant_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_tx_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin search. Picks the first set request
//            bit starting at ptr+1 and wrapping; the pointer register itself
//            lives in the parent.
// Ports    : req       - request vector
//            ptr       - index of the previous winner
//            grant     - one-hot grant (all zero when no request)
//            grant_idx - encoded index of the granted requester
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import serial_tx_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = grant_width(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic w_found;
    int   w_cand;

    // Offsets 1..NUM_REQ visit every requester once, the previous winner last
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_cand    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = (int'(ptr) + k) % NUM_REQ;
            if (!w_found && req[IDX_W'(w_cand)]) begin
                w_found               = 1'b1;
                grant[IDX_W'(w_cand)] = 1'b1;
                grant_idx             = IDX_W'(w_cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_scheduler
// Purpose  : Round-robin scheduler sharing one parallel-to-serial transmit
//            converter among NUM_REQ requesters. Latches the winner's word
//            and length, pulses tx_dv for one cycle, waits for tx_data_sent
//            and returns a one-cycle ack (or err for a zero-length word).
// Ports    : clk, rstn (async, active low)
//            req/req_data/req_len  - flattened requester inputs, slice i
//            ack/err               - one-cycle per-requester responses
//            busy                  - high in every state but IDLE
//            grant_id              - current/last granted requester
//            tx_dv/tx_din/tx_bit_length/tx_data_sent - converter interface
// Config   : TX_TIMEOUT_EN - when defined, a watchdog in WAIT_SENT returns
//            err after TIMEOUT_CYCLES cycles without tx_data_sent.
// Revision : 1.0 - initial release
// ============================================================================
module serial_tx_scheduler
    import serial_tx_pkg::*;
#(
    parameter int NUM_REQ             = 4,
    parameter int PARALLEL_PORT_WIDTH = c_DEF_PARALLEL_PORT_WIDTH,
    parameter int BIT_LENGTH          = c_DEF_BIT_LENGTH,
    parameter int TIMEOUT_CYCLES      = 64
)(
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [NUM_REQ-1:0]                     req,
    input  logic [NUM_REQ*PARALLEL_PORT_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*BIT_LENGTH-1:0]          req_len,
    output logic [NUM_REQ-1:0]                     ack,
    output logic [NUM_REQ-1:0]                     err,
    output logic                                   busy,
    output logic [grant_width(NUM_REQ)-1:0]        grant_id,
    output logic                                   tx_dv,
    output logic [PARALLEL_PORT_WIDTH-1:0]         tx_din,
    output logic [BIT_LENGTH-1:0]                  tx_bit_length,
    input  logic                                   tx_data_sent
);

    localparam int                 c_IDX_W   = grant_width(NUM_REQ);
    localparam logic [NUM_REQ-1:0] c_ONE_HOT = NUM_REQ'(1);

    logic [1:0]                     r_state;
    logic [c_IDX_W-1:0]             r_ptr;
    logic [c_IDX_W-1:0]             r_grant_id;
    logic [PARALLEL_PORT_WIDTH-1:0] r_tx_din;
    logic [BIT_LENGTH-1:0]          r_tx_len;
    logic [NUM_REQ-1:0]             r_ack;
    logic [NUM_REQ-1:0]             r_err;
    logic                           r_tx_dv;

    logic [NUM_REQ-1:0]             w_req_eff;
    logic [NUM_REQ-1:0]             w_grant;
    logic [c_IDX_W-1:0]             w_idx;
    logic [PARALLEL_PORT_WIDTH-1:0] w_sel_data;
    logic [BIT_LENGTH-1:0]          w_sel_len;

    // A requester that is seeing err this cycle has not yet had a chance to
    // drop req; masking it stops a duplicate rejection of the same word.
    assign w_req_eff = req & ~r_err;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_arb (
        .req       (w_req_eff),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_idx)
    );

    // One-hot mux of the winner's word and length
    always_comb begin
        w_sel_data = '0;
        w_sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_data = w_sel_data | req_data[i*PARALLEL_PORT_WIDTH +: PARALLEL_PORT_WIDTH];
                w_sel_len  = w_sel_len  | req_len[i*BIT_LENGTH +: BIT_LENGTH];
            end
        end
    end

`ifdef TX_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TO_W-1:0] r_to_cnt;
`else
    // No watchdog is built; the parameter only keeps the interface uniform.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= c_ST_IDLE;
            r_ptr      <= c_IDX_W'(NUM_REQ - 1);
            r_grant_id <= '0;
            r_tx_din   <= '0;
            r_tx_len   <= '0;
            r_ack      <= '0;
            r_err      <= '0;
            r_tx_dv    <= 1'b0;
`ifdef TX_TIMEOUT_EN
            r_to_cnt   <= '0;
`endif
        end else begin
            r_ack   <= '0;
            r_err   <= '0;
            r_tx_dv <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (|w_req_eff) begin
                        r_grant_id <= w_idx;
                        r_ptr      <= w_idx;
                        r_tx_din   <= w_sel_data;
                        r_tx_len   <= w_sel_len;
                        // The converter never completes a zero-length word
                        if (w_sel_len == '0) begin
                            r_err <= w_grant;
                        end else begin
                            r_tx_dv <= 1'b1;
                            r_state <= c_ST_ISSUE;
                        end
                    end
                end
                c_ST_ISSUE: begin
                    r_state <= c_ST_WAIT_SENT;
`ifdef TX_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                end
                c_ST_WAIT_SENT: begin
                    // Completion takes priority over a simultaneous expiry
                    if (tx_data_sent) begin
                        r_ack   <= c_ONE_HOT << r_grant_id;
                        r_state <= c_ST_GAP;
                    end
`ifdef TX_TIMEOUT_EN
                    else if (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1)) begin
                        r_err   <= c_ONE_HOT << r_grant_id;
                        r_state <= c_ST_GAP;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_TO_W'(1);
                    end
`endif
                end
                c_ST_GAP: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign ack           = r_ack;
    assign err           = r_err;
    assign busy          = (r_state != c_ST_IDLE);
    assign grant_id      = r_grant_id;
    assign tx_dv         = r_tx_dv;
    assign tx_din        = r_tx_din;
    assign tx_bit_length = r_tx_len;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_tx_scheduler
// Purpose  : Self-checking bench for serial_tx_scheduler. Stimulus pushes the
//            expected load/ack/err events into a scoreboard queue; a monitor
//            pops and compares each event the DUT presents. A small model of
//            the converter answers each load with data_sent after len+2
//            cycles. TX_TIMEOUT_EN adds the watchdog scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_tx_scheduler;

    localparam int NR = 4;
    localparam int PW = 15;
    localparam int BL = 4;
    localparam int IW = 2;
    localparam int TO = 16;

    localparam int K_DV  = 0;
    localparam int K_ACK = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int          kind;
        int          id;
        logic [PW-1:0] din;
        logic [BL-1:0] len;
        int          dly;
    } exp_t;

    logic             clk = 1'b0;
    logic             rstn;
    logic [NR-1:0]    req;
    logic [NR*PW-1:0] req_data;
    logic [NR*BL-1:0] req_len;
    logic [NR-1:0]    ack;
    logic [NR-1:0]    err;
    logic             busy;
    logic [IW-1:0]    grant_id;
    logic             tx_dv;
    logic [PW-1:0]    tx_din;
    logic [BL-1:0]    tx_bit_length;
    logic             tx_data_sent;
    logic             conv_sent;
    logic             stray_sent;
    logic             conv_en;

    exp_t          sbq[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            dv_cyc = 0;
    int            last_ack_cyc = -100;
    logic [PW-1:0] hold_din = '0;
    logic [BL-1:0] hold_len = '0;

    assign tx_data_sent = conv_sent | stray_sent;

    serial_tx_scheduler #(
        .NUM_REQ             (NR),
        .PARALLEL_PORT_WIDTH (PW),
        .BIT_LENGTH          (BL),
        .TIMEOUT_CYCLES      (TO)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .req           (req),
        .req_data      (req_data),
        .req_len       (req_len),
        .ack           (ack),
        .err           (err),
        .busy          (busy),
        .grant_id      (grant_id),
        .tx_dv         (tx_dv),
        .tx_din        (tx_din),
        .tx_bit_length (tx_bit_length),
        .tx_data_sent  (tx_data_sent)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_word(input int i, input logic [PW-1:0] d, input logic [BL-1:0] l);
        req_data[i*PW +: PW] = d;
        req_len[i*BL +: BL]  = l;
    endtask

    // Expected load followed by its ack, ack L+3 cycles after the load
    task automatic push_xfer(input int id, input logic [PW-1:0] d, input logic [BL-1:0] l);
        sbq.push_back('{K_DV, id, d, l, -1});
        sbq.push_back('{K_ACK, id, '0, '0, int'(l) + 3});
    endtask

    task automatic push_err(input int id, input int dly);
        sbq.push_back('{K_ERR, id, '0, '0, dly});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Runs until the scoreboard drains and the DUT is idle with no request.
    // stop_after==0: each requester drops req on its own ack/err.
    // stop_after>0 : all requests held until that many acks, then dropped.
    task automatic run_drain(input int max_cyc, input int stop_after);
        int acks = 0;
        bit done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge clk);
            #1;
            if (|ack) acks++;
            if (stop_after == 0) req = req & ~(ack | err);
            else if (acks >= stop_after) req = '0;
            if (sbq.size() == 0 && !busy && req == '0) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL drain_timeout: actual=%0d pending events, required=0 within %0d cycles",
                     sbq.size(), max_cyc);
        end
    endtask

    // Converter model: data_sent for one cycle, sampled L+2 cycles after load
    initial begin
        conv_sent = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_dv && conv_en && rstn) begin
                automatic int l = int'(tx_bit_length);
                repeat (l + 2) @(negedge clk);
                if (conv_en && rstn) conv_sent = 1'b1;
                @(negedge clk);
                conv_sent = 1'b0;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (tx_dv || (|ack) || (|err)) begin
                    check("ack_err_exclusive", {31'd0, (|ack) && (|err)}, 32'd0);
                    if (sbq.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_event: actual dv=%0b ack=%b err=%b, required none",
                                 tx_dv, ack, err);
                    end else begin
                        automatic exp_t e = sbq.pop_front();
                        automatic int   k = tx_dv ? K_DV : ((|ack) ? K_ACK : K_ERR);
                        check("sb_kind", k, e.kind);
                        if (k == K_DV && e.kind == K_DV) begin
                            check("sb_dv_grant_id", {30'd0, grant_id}, e.id);
                            check("sb_dv_din", {17'd0, tx_din}, {17'd0, e.din});
                            check("sb_dv_len", {28'd0, tx_bit_length}, {28'd0, e.len});
                            check("grant_spacing", {31'd0, (cyc - last_ack_cyc) >= 2}, 32'd1);
                            dv_cyc   = cyc;
                            hold_din = tx_din;
                            hold_len = tx_bit_length;
                        end else if (k == K_ACK && e.kind == K_ACK) begin
                            check("sb_ack_vec", {28'd0, ack}, 32'd1 << e.id);
                            if (e.dly >= 0) check("sb_ack_latency", cyc - dv_cyc, e.dly);
                            last_ack_cyc = cyc;
                        end else if (k == K_ERR && e.kind == K_ERR) begin
                            check("sb_err_vec", {28'd0, err}, 32'd1 << e.id);
                            if (e.dly >= 0) check("sb_err_latency", cyc - dv_cyc, e.dly);
                        end
                    end
                end
                if (busy && !tx_dv) begin
                    check("hold_din", {17'd0, tx_din}, {17'd0, hold_din});
                    check("hold_len", {28'd0, tx_bit_length}, {28'd0, hold_len});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        rstn       = 1'b0;
        req        = '0;
        req_data   = '0;
        req_len    = '0;
        conv_en    = 1'b1;
        stray_sent = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {28'd0, ack}, 32'd0);
        check("rst_err", {28'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tx_dv", {31'd0, tx_dv}, 32'd0);
        check("rst_tx_din", {17'd0, tx_din}, 32'd0);
        check("rst_tx_len", {28'd0, tx_bit_length}, 32'd0);
        check("rst_grant_id", {30'd0, grant_id}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Single requester: load one cycle after req sampled
        @(negedge clk);
        set_word(0, 15'h5A5A, 4'd8);
        push_xfer(0, 15'h5A5A, 4'd8);
        req = 4'b0001;
        @(posedge clk);
        #1;
        check("t1_dv_latency", {31'd0, tx_dv}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        run_drain(100, 0);

        // Two simultaneous requesters: 1 before 2
        @(negedge clk);
        set_word(1, 15'h1234, 4'd4);
        set_word(2, 15'h7FFF, 4'd4);
        push_xfer(1, 15'h1234, 4'd4);
        push_xfer(2, 15'h7FFF, 4'd4);
        req = 4'b0110;
        run_drain(100, 0);

        // Zero length: err next cycle, no load, stays idle
        @(negedge clk);
        set_word(3, 15'h1111, 4'd0);
        push_err(3, -1);
        req = 4'b1000;
        @(posedge clk);
        #1;
        check("zl_err", {28'd0, err}, 32'h8);
        check("zl_no_dv", {31'd0, tx_dv}, 32'd0);
        check("zl_idle", {31'd0, busy}, 32'd0);
        run_drain(20, 0);

        // Reset while waiting for the converter
        @(negedge clk);
        conv_en = 1'b0;
        set_word(2, 15'h0F0F, 4'd9);
        sbq.push_back('{K_DV, 2, 15'h0F0F, 4'd9, -1});
        req = 4'b0100;
        repeat (3) @(posedge clk);
        #1;
        check("wr_busy_in_wait", {31'd0, busy}, 32'd1);
        #2;
        rstn = 1'b0;
        req  = '0;
        #1;
        check("wr_async_busy", {31'd0, busy}, 32'd0);
        check("wr_async_din", {17'd0, tx_din}, 32'd0);
        check("wr_async_len", {28'd0, tx_bit_length}, 32'd0);
        check("wr_async_grant", {30'd0, grant_id}, 32'd0);
        check("wr_async_ack_err", {24'd0, ack, err}, 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (12) @(negedge clk);
        conv_en = 1'b1;
        check("wr_no_pending", sbq.size(), 32'd0);
        set_word(0, 15'h3C3C, 4'd2);
        set_word(3, 15'h4321, 4'd6);
        push_xfer(0, 15'h3C3C, 4'd2);
        push_xfer(3, 15'h4321, 4'd6);
        req = 4'b1001;
        run_drain(100, 0);

        // All four held continuously after reset: 0,1,2,3,0
        do_reset();
        @(negedge clk);
        set_word(0, 15'h0001, 4'd1);
        set_word(1, 15'h2AAA, 4'd15);
        set_word(2, 15'h5555, 4'd3);
        set_word(3, 15'h7F00, 4'd2);
        push_xfer(0, 15'h0001, 4'd1);
        push_xfer(1, 15'h2AAA, 4'd15);
        push_xfer(2, 15'h5555, 4'd3);
        push_xfer(3, 15'h7F00, 4'd2);
        push_xfer(0, 15'h0001, 4'd1);
        req = 4'b1111;
        run_drain(300, 5);

        // data_sent while idle is ignored
        @(negedge clk);
        stray_sent = 1'b1;
        @(negedge clk);
        stray_sent = 1'b0;
        #1;
        check("stray_no_ack", {28'd0, ack}, 32'd0);
        check("stray_idle", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);

`ifdef TX_TIMEOUT_EN
        // Converter silent: err TO cycles after entering WAIT_SENT
        @(negedge clk);
        conv_en = 1'b0;
        set_word(2, 15'h0ABC, 4'd5);
        sbq.push_back('{K_DV, 2, 15'h0ABC, 4'd5, -1});
        push_err(2, TO + 1);
        req = 4'b0100;
        run_drain(100, 0);
        conv_en = 1'b1;
        check("to_idle", {31'd0, busy}, 32'd0);
`endif

        repeat (2) @(negedge clk);
        check("sb_empty_at_end", sbq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_tx_scheduler.md
Name: serial_tx_scheduler

Overview:
- Round-robin scheduler that shares one parallel-to-serial transmit converter among NUM_REQ requesters.
- Arbitrates requests, latches the winner's word and bit length, and issues a one-cycle load pulse to the converter.
- Waits for the converter's one-cycle data_sent pulse, then returns a per-requester ack.
- Sits between bus-master logic and the serial line driver.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
PARALLEL_PORT_WIDTH, 15, converter data width
BIT_LENGTH, 4, width of the bit-length field
TIMEOUT_CYCLES, 64, watchdog limit in WAIT_SENT (used only with TX_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic on posedge
rstn  in  1  asynchronous active-low reset
req  in  NUM_REQ  level request per requester; hold until ack/err
req_data  in  NUM_REQ*PARALLEL_PORT_WIDTH  flattened words, requester i at slice i
req_len  in  NUM_REQ*BIT_LENGTH  flattened bit lengths, requester i at slice i
ack  out  NUM_REQ  one-cycle pulse: requester's word fully sent
err  out  NUM_REQ  one-cycle pulse: request rejected (zero length) or timed out
busy  out  1  high in every state except IDLE
grant_id  out  clog2(NUM_REQ)  index of current/last granted requester
tx_dv  out  1  one-cycle load pulse to converter dv_in
tx_din  out  PARALLEL_PORT_WIDTH  latched word to converter din
tx_bit_length  out  BIT_LENGTH  latched length to converter bit_length
tx_data_sent  in  1  converter completion pulse

Behaviour:
- Reset (asynchronous, any state):
  - State to IDLE.
  - ack, err, tx_dv, busy, tx_din, tx_bit_length and grant_id all 0.
  - Round-robin pointer set to NUM_REQ-1, so requester 0 wins first.
  - An in-flight transfer is dropped with no ack/err; the converter shares rstn.
- IDLE:
  - If any req bit is set, pick the first set bit searching from pointer+1 upward with wrap.
  - Latch that requester's data and len into tx_din/tx_bit_length; set grant_id; update pointer to the winner.
  - If latched len==0: pulse err[winner] next cycle and stay in IDLE. The converter would never pulse data_sent for a zero length.
  - Otherwise go to ISSUE.
- ISSUE:
  - tx_dv=1 for exactly this cycle, then go to WAIT_SENT.
  - Latency: req sampled at edge k gives tx_dv high in cycle k+1.
- WAIT_SENT:
  - tx_din and tx_bit_length are held stable.
  - On tx_data_sent=1: pulse ack[grant_id] in the next cycle and go to GAP.
- GAP:
  - One idle turnaround cycle with tx_dv=0, then go to IDLE.
  - A requester still holding req after ack is re-arbitrated fairly behind the others.
- Requester rules:
  - Once granted, dropping req does not abort the transfer; data is already latched.
  - A req dropped before grant is simply not served.
- Timing: for a converter length L, ack rises L+3 cycles after tx_dv.
- Ordering and exclusivity:
  - ack and err are mutually exclusive and one-hot.
  - Back-to-back grants are spaced at least 2 cycles apart: the GAP cycle plus arbitration in IDLE.
- tx_data_sent outside WAIT_SENT is ignored.

Optional Feature:
- Macro: TX_TIMEOUT_EN.
- Defined:
  - WAIT_SENT runs a counter cleared on entry.
  - If TIMEOUT_CYCLES cycles pass without tx_data_sent, pulse err[grant_id] and go to GAP.
  - tx_data_sent in the same cycle as expiry wins and produces ack.
- Undefined: no counter is built; WAIT_SENT waits indefinitely.

Decomposition:
- Package serial_tx_pkg:
  - state encoding: IDLE, ISSUE, WAIT_SENT, GAP (2 bits)
  - default PARALLEL_PORT_WIDTH and BIT_LENGTH constants
  - grant index width function
- Sub-module rr_arbiter:
  - inputs: req vector and pointer
  - outputs: one-hot grant and encoded index
  - combinational search; the pointer register lives in the parent.

Test Plan:
- req=0001, data=0x5A5A, len=8 -> tx_dv one cycle after req sampled; tx_din=0x5A5A held stable; ack[0] one cycle after tx_data_sent.
- req=0110 simultaneous, both len=4 -> grant 1 then 2, acks in that order, at least 2 cycles between grants.
- req=1111 held continuously after reset -> grant sequence 0,1,2,3,0; each requester gets one ack per round.
- req[3] with len=0 -> err[3] pulses, no tx_dv, no ack, state returns to IDLE.
- rstn low during WAIT_SENT -> all outputs 0 asynchronously; no ack/err after release; next grant is requester 0.
- TX_TIMEOUT_EN, TIMEOUT_CYCLES=16, tx_data_sent tied 0 -> err[grant_id] 16 cycles after WAIT_SENT entry, then GAP and IDLE.
